// File: rtl/com_sprom_pkg.sv
// Shared types and helpers for the com_sprom read-side stream master.
package com_sprom_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_st_e;

    localparam int unsigned RD_LAT_MAX = 2;

    // Increment with wrap at depth; depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned val, input int unsigned depth);
        return (val + 1 >= depth) ? 0 : val + 1;
    endfunction

endpackage

// File: rtl/com_sync_fifo_sa.sv
// Small show-ahead FIFO with fall-through when empty and a synchronous flush.
module com_sync_fifo_sa #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             empty;
    logic             do_pop;
    logic             do_write;
    logic             do_read;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (count_q == '0);
    assign head_valid = ~empty | push;
    assign head_data  = !empty ? mem_q[rd_ptr_q] : (push ? push_data : '0);
    assign count      = count_q;

    // A word pushed into an empty FIFO and popped in the same cycle is never stored.
    assign do_pop   = pop & head_valid;
    assign do_write = push & ~(empty & do_pop);
    assign do_read  = do_pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_read) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_write) - CNT_W'(do_read);
        end
    end

endmodule

// File: rtl/com_sprom_rd_stream.sv
// Read-side master for com_sprom ROM wrappers: turns (addr, len) commands into a
// valid/ready word stream with last, absorbing the fixed ROM read latency.
module com_sprom_rd_stream
    import com_sprom_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              abort,
    output logic              busy,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_rd_addr,
    input  logic [DATA_W-1:0] rom_rd_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last
);

    localparam int unsigned BUF_D = RD_LAT + 1;
    localparam int unsigned CNT_W = $clog2(BUF_D + 1);

    rd_st_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0] pipe_last_q, pipe_last_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic [DATA_W:0]   fifo_head;
    logic              credit;
    logic              issue;
    logic              cmd_fire;
    logic              is_last_rd;

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = ~cmd_ready;
    assign cmd_fire   = cmd_valid & cmd_ready & ~abort;
    assign is_last_rd = (rem_q == (ADDR_W + 1)'(1));

    // Every issued read owns a FIFO slot until popped, so the buffer cannot overflow.
    assign credit = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(BUF_D);
    assign issue  = (state_q == ISSUE) & credit & ~abort;

    assign rom_rd_en   = issue;
    assign rom_rd_addr = addr_q;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_vld_q[i]);
        end
    end

    always_comb begin
        pipe_vld_d  = '0;
        pipe_last_d = '0;
        if (!abort) begin
            pipe_vld_d[0]  = issue;
            pipe_last_d[0] = issue & is_last_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_d[i]  = pipe_vld_q[i-1];
                pipe_last_d[i] = pipe_last_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    addr_d = ADDR_W'(wrap_inc(32'(addr_q), DEPTH));
                    rem_d  = rem_q - 1'b1;
                    if (is_last_rd) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (dout_valid && dout_ready && dout_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    com_sync_fifo_sa #(
        .WIDTH(DATA_W + 1),
        .DEPTH(BUF_D)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (pipe_vld_q[RD_LAT-1]),
        .push_data ({pipe_last_q[RD_LAT-1], rom_rd_data}),
        .pop       (dout_ready),
        .head_valid(dout_valid),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign dout_last = fifo_head[DATA_W];
    assign dout_data = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_com_sprom_rd_stream.sv
// Scoreboard bench: three DUTs (DEPTH 64/RD_LAT 1, 64/2, 48/1) share stimulus,
// each with its own ROM model, expected-beat queue and output monitor.
module tb_com_sprom_rd_stream;

    localparam int NI = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_go;
    logic [2:0] cmd_mask;
    logic [5:0] cmd_addr;
    logic [6:0] cmd_len;
    logic       abort;
    logic       dout_ready;

    logic        cmd_valid   [NI];
    logic        cmd_ready   [NI];
    logic        busy        [NI];
    logic        rom_rd_en   [NI];
    logic [5:0]  rom_rd_addr [NI];
    logic [31:0] rom_rd_data [NI];
    logic        dout_valid  [NI];
    logic [31:0] dout_data   [NI];
    logic        dout_last   [NI];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 0;  // 0: ready held high, 1: random ready, 2: ready held low
    int pend [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned D   = (g == 2) ? 48 : 64;
        localparam int unsigned LAT = (g == 1) ? 2 : 1;
        localparam int          BUF = LAT + 1;

        beat_t       exp_q [$];
        logic [31:0] rom_pipe [2];
        int          reads_left, exp_addr, outstanding, acc_cyc, beat_idx;
        bit          full_rate, hold_v, hold_l, post_end;
        logic [31:0] hold_d;
        beat_t       b;

        assign cmd_valid[g] = cmd_go & cmd_mask[g];

        com_sprom_rd_stream #(
            .DATA_W(32),
            .DEPTH (D),
            .RD_LAT(LAT)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_addr   (cmd_addr),
            .cmd_len    (cmd_len),
            .abort      (abort),
            .busy       (busy[g]),
            .rom_rd_en  (rom_rd_en[g]),
            .rom_rd_addr(rom_rd_addr[g]),
            .rom_rd_data(rom_rd_data[g]),
            .dout_valid (dout_valid[g]),
            .dout_ready (dout_ready),
            .dout_data  (dout_data[g]),
            .dout_last  (dout_last[g])
        );

        // ROM: word[i] = A000_0000 + i after LAT cycles; junk when no read was issued.
        always @(posedge clk) begin
            rom_pipe[0] <= rom_rd_en[g] ? (32'hA000_0000 + {26'd0, rom_rd_addr[g]})
                                        : {16'hDEAD, 16'($urandom)};
            rom_pipe[1] <= rom_pipe[0];
        end
        assign rom_rd_data[g] = rom_pipe[LAT-1];

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                reads_left  = 0;
                outstanding = 0;
                hold_v      = 0;
                post_end    = 0;
            end else begin
                if (post_end) begin
                    chk_eq($sformatf("u%0d idle_after_end", g), {busy[g], dout_valid[g]}, 0);
                    post_end = 0;
                end
                if (hold_v) begin
                    chk_eq($sformatf("u%0d hold_stable", g),
                           {dout_valid[g], dout_last[g], dout_data[g]}, {1'b1, hold_l, hold_d});
                end
                if (rom_rd_en[g]) begin
                    chk_eq($sformatf("u%0d rd_credit", g), rom_rd_en[g] && outstanding >= BUF, 0);
                    chk_eq($sformatf("u%0d rd_extra", g), rom_rd_en[g] && reads_left == 0, 0);
                    chk_eq($sformatf("u%0d rd_addr", g), rom_rd_addr[g], exp_addr);
                    reads_left--;
                    exp_addr = (exp_addr + 1) % D;
                    outstanding++;
                end
                if (dout_valid[g] && !abort) begin
                    if (exp_q.size() == 0) begin
                        chk_eq($sformatf("u%0d unexpected_valid", g), dout_valid[g], 0);
                    end else if (dout_ready) begin
                        b = exp_q.pop_front();
                        chk_eq($sformatf("u%0d beat", g), {dout_last[g], dout_data[g]},
                               {b.last, b.data});
                        if (full_rate) begin
                            chk_eq($sformatf("u%0d beat_cycle", g), cyc,
                                   acc_cyc + LAT + 1 + beat_idx);
                        end
                        beat_idx++;
                        outstanding--;
                        post_end = b.last;
                    end
                end
                hold_v = dout_valid[g] && !dout_ready && !abort;
                hold_d = dout_data[g];
                hold_l = dout_last[g];
                if (cmd_valid[g] && cmd_ready[g] && !abort) begin
                    for (int k = 0; k < int'(cmd_len); k++) begin
                        b.data = 32'hA000_0000 + 32'((int'(cmd_addr) + k) % D);
                        b.last = (k == int'(cmd_len) - 1);
                        exp_q.push_back(b);
                    end
                    reads_left = int'(cmd_len);
                    exp_addr   = int'(cmd_addr);
                    acc_cyc    = cyc;
                    beat_idx   = 0;
                    full_rate  = (rdy_mode == 0);
                end
                if (abort) begin
                    exp_q.delete();
                    reads_left  = 0;
                    outstanding = 0;
                    post_end    = 1;
                end
            end
            pend[g] = exp_q.size();
        end
    end

    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            dout_ready = (rdy_mode == 0) ? 1'b1 :
                         (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] mask, input int a, input int l);
        cmd_mask = mask;
        cmd_addr = 6'(a);
        cmd_len  = 7'(l);
        cmd_go   = 1'b1;
        tick();
        cmd_go   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) chk_eq("idle_timeout", n, 0);
        tick();
        for (int g = 0; g < NI; g++) chk_eq($sformatf("u%0d pending_beats", g), pend[g], 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk_eq($sformatf("%s u%0d cmd_ready", tag, g), cmd_ready[g], 1);
            chk_eq($sformatf("%s u%0d busy", tag, g), busy[g], 0);
            chk_eq($sformatf("%s u%0d rom_rd_en", tag, g), rom_rd_en[g], 0);
            chk_eq($sformatf("%s u%0d rom_rd_addr", tag, g), rom_rd_addr[g], 0);
            chk_eq($sformatf("%s u%0d dout_valid", tag, g), dout_valid[g], 0);
            chk_eq($sformatf("%s u%0d dout_data", tag, g), dout_data[g], 0);
            chk_eq($sformatf("%s u%0d dout_last", tag, g), dout_last[g], 0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cmd_go   = 1'b0;
        cmd_mask = '0;
        cmd_addr = '0;
        cmd_len  = '0;
        abort    = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        rdy_mode = 0;
        tick();
        send(3'b111, 5, 4);
        wait_idle();
        send(3'b011, 62, 4);
        wait_idle();
        send(3'b100, 46, 3);
        wait_idle();

        send(3'b111, 7, 0);
        for (int g = 0; g < NI; g++) begin
            chk_eq($sformatf("u%0d len0_cmd_ready", g), cmd_ready[g], 1);
            chk_eq($sformatf("u%0d len0_busy", g), busy[g], 0);
        end
        repeat (4) tick();

        for (int n = 0; n < 14; n++) begin
            rdy_mode = (n % 3 == 0) ? 0 : 1;
            tick();
            send(3'b111, $urandom_range(0, 47), (n == 1) ? 16 : $urandom_range(1, 40));
            wait_idle();
        end

        rdy_mode = 2;
        tick();
        send(3'b111, $urandom_range(0, 47), 32);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (2) tick();
        rdy_mode = 0;
        tick();
        send(3'b111, 0, 2);
        wait_idle();

        send(3'b111, 20, 20);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(3'b111, 10, 3);
        wait_idle();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
